// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder_pkg
//  Purpose  : Shared CPU definitions: opcodes, instruction formats, encoder
//             FSM state encoding and instruction FIFO depth.
//  Revision : 1.0  initial release
// ============================================================================
package instr_encoder_pkg;

    // Datapath widths
    localparam int c_ADDR_W  = 16;
    localparam int c_INSTR_W = 16;

    // Encoded-word FIFO depth
    localparam int c_FIFO_DEPTH = 4;

    // Opcodes
    localparam logic [3:0] c_OP_ADD = 4'h0;
    localparam logic [3:0] c_OP_SUB = 4'h1;
    localparam logic [3:0] c_OP_AND = 4'h2;
    localparam logic [3:0] c_OP_OR  = 4'h3;
    localparam logic [3:0] c_OP_SLL = 4'h4;
    localparam logic [3:0] c_OP_SRL = 4'h5;
    localparam logic [3:0] c_OP_SRA = 4'h6;
    localparam logic [3:0] c_OP_XOR = 4'h7;
    localparam logic [3:0] c_OP_LW  = 4'h8;
    localparam logic [3:0] c_OP_SW  = 4'h9;
    localparam logic [3:0] c_OP_LI  = 4'hA;
    localparam logic [3:0] c_OP_LUI = 4'hB;
    localparam logic [3:0] c_OP_B   = 4'hC;
    localparam logic [3:0] c_OP_BR  = 4'hD;
    localparam logic [3:0] c_OP_JR  = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    // Encoder FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_RUN   = c_ST_RUN,
        ST_DRAIN = c_ST_DRAIN,
        ST_DONE  = c_ST_DONE
    } state_t;

    // Instruction field layouts, shared with the decode side
    typedef enum logic [2:0] {
        FMT_RRR  = 3'd0,  // {op,rd,rs,rt}
        FMT_RRI4 = 3'd1,  // {op,rd,rs,imm4} unsigned shift amount
        FMT_MEM  = 3'd2,  // {op,rt,rs,imm4} signed offset
        FMT_RI8  = 3'd3,  // {op,rd,imm8}
        FMT_BR   = 3'd4,  // {op,ccc,imm9}
        FMT_BRR  = 3'd5,  // {op,ccc,0,rs,0000}
        FMT_R    = 3'd6,  // {op,rd,00000000}
        FMT_NONE = 3'd7   // {op,000000000000}
    } fmt_t;

    function automatic fmt_t op_format(input logic [3:0] op);
        fmt_t f;
        case (op)
            c_OP_SLL, c_OP_SRL, c_OP_SRA: f = FMT_RRI4;
            c_OP_LW,  c_OP_SW:            f = FMT_MEM;
            c_OP_LI,  c_OP_LUI:           f = FMT_RI8;
            c_OP_B:                       f = FMT_BR;
            c_OP_BR:                      f = FMT_BRR;
            c_OP_JR:                      f = FMT_R;
            c_OP_HLT:                     f = FMT_NONE;
            default:                      f = FMT_RRR;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder_if
//  Purpose  : Request-in / memory-write-out handshake bundle of the
//             instruction encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    // Request side
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_op;
    logic [3:0]            req_rd;
    logic [3:0]            req_rs;
    logic [3:0]            req_rt;
    logic [2:0]            req_ccc;
    logic [8:0]            req_imm;

    // Memory-write side
    logic                  out_valid;
    logic                  out_ready;
    logic [c_ADDR_W-1:0]   out_addr;
    logic [c_INSTR_W-1:0]  out_instr;

    // Request producer / write-port consumer
    modport master (
        output req_valid, req_op, req_rd, req_rs, req_rt, req_ccc, req_imm,
        input  req_ready,
        input  out_valid, out_addr, out_instr,
        output out_ready
    );

    // Encoder
    modport slave (
        input  req_valid, req_op, req_rd, req_rs, req_rt, req_ccc, req_imm,
        output req_ready,
        output out_valid, out_addr, out_instr,
        input  out_ready
    );

endinterface
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fifo
//  Purpose  : Small FIFO of encoded instruction words; head is presented
//             combinationally so a pushed word is visible one edge later.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fifo
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = c_FIFO_DEPTH,
    parameter int WIDTH = c_INSTR_W
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_head,
    output logic      [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Guard against overflow/underflow using the registered occupancy only
    assign w_do_push = i_push && (r_count != c_CW'(DEPTH));
    assign w_do_pop  = i_pop  && (r_count != '0);

    // Storage is not reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Encodes instruction requests into 16-bit words, rejects
//             out-of-range fields, buffers words in a FIFO and streams them
//             to instruction memory at consecutive addresses until HLT.
//  Revision : 1.0  initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 start,
    input  wire logic [c_ADDR_W-1:0]  start_addr,
    output logic                      err,
    output logic                      done,
    instr_encoder_if.slave            bus
);

    localparam int c_CW = $clog2(c_FIFO_DEPTH) + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_ADDR_W-1:0]   r_addr;
    logic                  r_err;
    logic [c_INSTR_W-1:0]  w_word;
    logic                  w_legal;
    fmt_t                  w_fmt;
    logic [c_INSTR_W-1:0]  w_head;
    logic [c_CW-1:0]       w_count;
    logic                  w_req_ready;
    logic                  w_req_fire;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;

    // Registered occupancy only: a pop this cycle cannot open a slot for a push
    assign w_req_ready = (r_state == ST_RUN) && (w_count < c_CW'(c_FIFO_DEPTH));
    assign w_req_fire  = bus.req_valid && w_req_ready;
    assign w_push      = w_req_fire && w_legal;
    assign w_pop       = (w_count != '0) && bus.out_ready;
    assign w_load      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Field packing and range checking, selected by the opcode's format
    always_comb begin
        w_fmt   = op_format(bus.req_op);
        w_word  = '0;
        w_legal = 1'b1;
        case (w_fmt)
            FMT_RRR:  w_word = {bus.req_op, bus.req_rd, bus.req_rs, bus.req_rt};
            FMT_RRI4: begin
                w_word  = {bus.req_op, bus.req_rd, bus.req_rs, bus.req_imm[3:0]};
                w_legal = (bus.req_imm[8:4] == 5'd0);
            end
            FMT_MEM: begin
                // Offset must be a sign-extended 4-bit value
                w_word  = {bus.req_op, bus.req_rt, bus.req_rs, bus.req_imm[3:0]};
                w_legal = (bus.req_imm[8:4] == {5{bus.req_imm[3]}});
            end
            FMT_RI8: begin
                w_word  = {bus.req_op, bus.req_rd, bus.req_imm[7:0]};
                w_legal = !bus.req_imm[8];
            end
            FMT_BR:   w_word = {bus.req_op, bus.req_ccc, bus.req_imm};
            FMT_BRR:  w_word = {bus.req_op, bus.req_ccc, 1'b0, bus.req_rs, 4'h0};
            FMT_R:    w_word = {bus.req_op, bus.req_rd, 8'h00};
            default:  w_word = {bus.req_op, 12'h000};
        endcase
    end

    instr_fifo #(
        .DEPTH (c_FIFO_DEPTH),
        .WIDTH (c_INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: HLT moves to DRAIN; DRAIN ends when the last word leaves
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_push && (bus.req_op == c_OP_HLT)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && (w_count == c_CW'(1))) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address of the FIFO head: loaded on start, advanced per written beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (w_load) begin
            r_addr <= start_addr;
        end else if (w_pop) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Error pulse in the cycle after an illegal request is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_req_fire && !w_legal;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = (w_count != '0);
    assign bus.out_addr  = r_addr;
    assign bus.out_instr = w_head;
    assign err           = r_err;
    assign done          = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking bench for instr_encoder with a queue-based
//             reference model of the encoder's externally visible behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = 16'h0000;
    logic        err;
    logic        done;

    instr_encoder_if bus();

    instr_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .err        (err),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_state;
    bit [15:0]   m_addr;
    bit          m_err;
    bit [15:0]   q[$];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_word(input int op, input int rd, input int rs,
                                    input int rt, input int ccc, input int imm);
        int hi;
        hi = op * 4096;
        case (op)
            4, 5, 6: return hi + rd * 256 + rs * 16 + imm % 16;
            8, 9:    return hi + rt * 256 + rs * 16 + imm % 16;
            10, 11:  return hi + rd * 256 + imm % 256;
            12:      return hi + ccc * 512 + imm;
            13:      return hi + ccc * 512 + rs * 16;
            14:      return hi + rd * 256;
            15:      return hi;
            default: return hi + rd * 256 + rs * 16 + rt;
        endcase
    endfunction

    function automatic bit ref_legal(input int op, input int imm);
        case (op)
            4, 5, 6: return imm < 16;
            8, 9:    return (imm < 8) || (imm >= 504);
            10, 11:  return imm < 256;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_addr  = 16'h0000;
        m_err   = 1'b0;
        q.delete();
    endtask

    // One clock: check outputs at negedge, predict the coming edge, return handshake
    task automatic tick(output bit hs);
        bit ready, pop, legal;
        int op, imm;
        @(negedge clk);
        ready = (m_state == M_RUN) && (q.size() < 4);
        chk("req_ready", bus.req_ready, ready);
        chk("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_instr", bus.out_instr, q[0]);
            chk("out_addr", bus.out_addr, m_addr);
        end
        chk("err", err, m_err);
        chk("done", done, m_state == M_DONE);
        op    = int'(bus.req_op);
        imm   = int'(bus.req_imm);
        pop   = (q.size() != 0) && bus.out_ready;
        hs    = bus.req_valid && ready;
        legal = ref_legal(op, imm);
        m_err = hs && !legal;
        if (pop) begin
            void'(q.pop_front());
            m_addr = m_addr + 16'd1;
        end
        if (hs && legal)
            q.push_back(16'(ref_word(op, int'(bus.req_rd), int'(bus.req_rs),
                                     int'(bus.req_rt), int'(bus.req_ccc), imm)));
        case (m_state)
            M_IDLE, M_DONE: if (start) begin m_state = M_RUN; m_addr = start_addr; end
            M_RUN:   if (hs && legal && op == 15) m_state = M_DRAIN;
            M_DRAIN: if (q.size() == 0) m_state = M_DONE;
            default: m_state = M_IDLE;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit hs;
        for (int i = 0; i < n; i++) tick(hs);
    endtask

    task automatic send(input int op, input int rd, input int rs, input int rt,
                        input int ccc, input int imm);
        bit hs;
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_op  = 4'(op);  bus.req_rd = 4'(rd); bus.req_rs = 4'(rs);
        bus.req_rt  = 4'(rt);  bus.req_ccc = 3'(ccc); bus.req_imm = 9'(imm);
        do begin
            tick(hs);
            n++;
        end while (!hs && n < 20);
        bus.req_valid = 1'b0;
        chk("send_handshake", hs, 1'b1);
    endtask

    task automatic pulse_start(input logic [15:0] a);
        bit hs;
        start_addr = a;
        start = 1'b1;
        tick(hs);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit hs;
        int n;
        n = 0;
        while (m_state != M_DONE && n < 50) begin
            tick(hs);
            n++;
        end
        chk("drain_timeout", m_state == M_DONE, 1'b1);
    endtask

    initial begin
        bit hs;
        int n;
        bus.req_valid = 1'b0; bus.out_ready = 1'b0;
        bus.req_op = '0; bus.req_rd = '0; bus.req_rs = '0; bus.req_rt = '0;
        bus.req_ccc = '0; bus.req_imm = '0;
        model_reset();

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_addr", bus.out_addr, 16'h0000);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Basic encodings
        pulse_start(16'h0100);
        bus.out_ready = 1'b1;
        send(0, 1, 2, 3, 0, 0);
        chk("add_word", bus.out_instr, 16'h0123);
        chk("add_addr", bus.out_addr, 16'h0100);
        send(8, 0, 5, 4, 0, 9'h1F8);
        chk("lw_word", bus.out_instr, 16'h8458);
        send(4, 1, 1, 0, 0, 9'h010);
        chk("sll_err", err, 1'b1);
        chk("sll_addr", bus.out_addr, 16'h0102);
        chk("sll_empty", bus.out_valid, 1'b0);
        send(12, 0, 0, 0, 5, 9'h1FF);
        send(13, 0, 7, 0, 2, 0);
        chk("br_word", bus.out_instr, 16'hD470);
        idle(1);

        // Back-pressure: fill four, fifth stalls
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1, i, i + 1, i + 2, 0, 0);
        chk("full_ready", bus.req_ready, 1'b0);
        bus.req_valid = 1'b1; bus.req_op = 4'hA; bus.req_rd = 4'h9; bus.req_imm = 9'h0AB;
        for (int i = 0; i < 3; i++) begin
            tick(hs);
            chk("stall_hs", hs, 1'b0);
        end
        bus.out_ready = 1'b1;
        n = 0;
        do begin tick(hs); n++; end while (!hs && n < 10);
        bus.req_valid = 1'b0;
        chk("unstall_hs", hs, 1'b1);
        idle(6);

        // Randomized traffic; stray start pulses must be ignored
        for (int i = 0; i < 300; i++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_op    = 4'($urandom_range(0, 14));
            bus.req_rd    = 4'($urandom); bus.req_rs = 4'($urandom);
            bus.req_rt    = 4'($urandom); bus.req_ccc = 3'($urandom);
            bus.req_imm   = 9'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            start         = ($urandom_range(0, 19) == 0);
            start_addr    = 16'($urandom);
            tick(hs);
        end
        start = 1'b0;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        send(15, 0, 0, 0, 0, 0);
        wait_done();
        chk("done_level", done, 1'b1);

        // Address wrap with a full program and HLT
        pulse_start(16'hFFFE);
        bus.out_ready = 1'b0;
        send(2, 3, 4, 5, 0, 0);
        send(10, 6, 0, 0, 0, 9'h0FF);
        send(9, 0, 1, 2, 0, 9'h007);
        send(15, 0, 0, 0, 0, 0);
        chk("wrap_base", bus.out_addr, 16'hFFFE);
        idle(2);
        bus.out_ready = 1'b1;
        wait_done();
        chk("wrap_end_addr", bus.out_addr, 16'h0002);
        chk("wrap_done", done, 1'b1);

        // Reset with words queued discards them
        pulse_start(16'h2000);
        bus.out_ready = 1'b0;
        send(3, 1, 1, 1, 0, 0);
        send(7, 2, 2, 2, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_req_ready", bus.req_ready, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        pulse_start(16'h3000);
        bus.out_ready = 1'b1;
        idle(4);
        chk("post_rst_addr", bus.out_addr, 16'h3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
